// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse-measurement blocks.
package pulse_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      HIGH = 2'b01,
      LOW  = 2'b10
   } state_t;

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer for DATA_IN with registered rise/fall detection.
module pulse_sync_edge (
   input  logic CLK_IN,
   input  logic rst_n,
   input  logic DATA_IN,
   output logic s,
   output logic rise,
   output logic fall
);

   logic       sync1;
   logic       sync2;
   logic       s_d;
   logic       armed;
   logic [1:0] fill;

   // Edges are suppressed until a low level has been seen after reset, so an
   // input already high at release is not mistaken for a fresh rising edge.
   always_ff @(posedge CLK_IN or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         s_d   <= 1'b0;
         fill  <= '0;
         armed <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync1 <= DATA_IN;
         sync2 <= sync1;
         s_d   <= sync2;
         fill  <= {fill[0], 1'b1};
         if (fill[1] && !sync2)
            armed <= 1'b1;
         rise  <= armed & sync2 & ~s_d;
         fall  <= armed & ~sync2 & s_d;
      end
   end

   // s_d is the level aligned with the registered rise/fall pulses.
   assign s = s_d;

endmodule

// File: rtl/pulse_meter.sv
// Measures high time and rising-edge period of DATA_IN in CLK_IN cycles.
module pulse_meter
   import pulse_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1000,
   parameter int unsigned CNT_W   = 21
) (
   input  logic             CLK_IN,
   input  logic             rst_n,
   input  logic             DATA_IN,
   input  logic             meas_ready,
   output logic             meas_valid,
   output logic [CNT_W-1:0] meas_width,
   output logic [CNT_W-1:0] meas_period,
   output logic             timeout,
   output logic             overrun,
   output logic             busy
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] wcnt;
   logic [CNT_W-1:0] pcnt;
   logic             s;
   logic             rise;
   logic             fall;
   logic             at_limit;
   logic             publish;

   pulse_sync_edge u_sync (
      .CLK_IN  (CLK_IN),
      .rst_n   (rst_n),
      .DATA_IN (DATA_IN),
      .s       (s),
      .rise    (rise),
      .fall    (fall)
   );

   assign at_limit = (pcnt == TIMEOUT_C);

   always_ff @(posedge CLK_IN or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (rise) state_nxt = HIGH;
         HIGH: begin
            if (at_limit && !rise) state_nxt = IDLE;
            else if (fall)         state_nxt = LOW;
         end
         LOW: begin
            if (rise)          state_nxt = HIGH;
            else if (at_limit) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state != IDLE);
      timeout = (state != IDLE) && at_limit && !rise;
      publish = (state == LOW) && rise;
   end

   always_ff @(posedge CLK_IN or negedge rst_n) begin
      if (!rst_n) begin
         wcnt <= '0;
         pcnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               wcnt <= rise ? ONE_C : '0;
               pcnt <= rise ? ONE_C : '0;
            end
            HIGH: begin
               if (timeout) begin
                  wcnt <= '0;
                  pcnt <= '0;
               end else begin
                  pcnt <= pcnt + ONE_C;
                  if (s && !fall)
                     wcnt <= wcnt + ONE_C;
               end
            end
            LOW: begin
               if (rise) begin
                  wcnt <= ONE_C;
                  pcnt <= ONE_C;
               end else if (timeout) begin
                  wcnt <= '0;
                  pcnt <= '0;
               end else begin
                  pcnt <= pcnt + ONE_C;
               end
            end
            default: begin
               wcnt <= '0;
               pcnt <= '0;
            end
         endcase
      end
   end

   // A result held without acceptance is never overwritten; the newer one is lost.
   always_ff @(posedge CLK_IN or negedge rst_n) begin
      if (!rst_n) begin
         meas_valid  <= 1'b0;
         meas_width  <= '0;
         meas_period <= '0;
         overrun     <= 1'b0;
      end else begin
         if (publish) begin
            if (!meas_valid || meas_ready) begin
               meas_valid  <= 1'b1;
               meas_width  <= wcnt;
               meas_period <= pcnt;
            end else begin
               overrun <= 1'b1;
            end
         end else if (meas_ready) begin
            meas_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/pulse_meter.md
PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 1000, giving the maximum cycles between rising edges before a measurement is abandoned.
REQ-002 The block SHALL have parameter CNT_W, default 21, giving the width of the width and period counters; TIMEOUT SHALL fit in CNT_W bits.
REQ-003 The block SHALL have port CLK_IN, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port DATA_IN, input, 1 bit: asynchronous pulse input under test.
REQ-006 The block SHALL have port meas_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-007 The block SHALL have port meas_valid, output, 1 bit: a result is held on meas_width/meas_period.
REQ-008 The block SHALL have port meas_width, output, CNT_W bits: high time in CLK_IN cycles.
REQ-009 The block SHALL have port meas_period, output, CNT_W bits: rising-edge to rising-edge time in cycles.
REQ-010 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when a measurement is abandoned.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky flag set when a result is dropped.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-013 DATA_IN SHALL pass through a two-flop synchronizer to give s, with delayed copy s_d; rise = s & ~s_d; fall = ~s & s_d.
REQ-014 A DATA_IN transition SHALL produce rise/fall 3 cycles later: 2 synchronizer cycles plus 1 edge-register cycle.
REQ-015 The FSM SHALL have states IDLE, HIGH and LOW.
REQ-016 IDLE: on rise, the FSM SHALL go to HIGH with wcnt=1 and pcnt=1; otherwise the counters SHALL hold 0.
REQ-017 HIGH: pcnt SHALL increment each cycle; wcnt SHALL increment while s=1; on fall, the FSM SHALL go to LOW and wcnt SHALL NOT increment in the fall cycle.
REQ-018 LOW: pcnt SHALL increment each cycle; on rise, the FSM SHALL publish width=wcnt and period=pcnt (pre-increment values), reload wcnt=1 and pcnt=1, and go to HIGH for back-to-back measurement.
REQ-019 In HIGH or LOW, when pcnt equals TIMEOUT with no rise that cycle, the FSM SHALL go to IDLE, pulse timeout for 1 cycle, publish nothing, and clear the counters.
REQ-020 If a rise and pcnt==TIMEOUT occur in the same cycle, the rise SHALL win (publish, no timeout).
REQ-021 A publish SHALL load the output register and assert meas_valid on the next cycle; the output SHALL hold stable while meas_valid=1 and meas_ready=0.
REQ-022 The output register SHALL clear meas_valid in the cycle after meas_valid & meas_ready, unless a new publish occurs in the same cycle, in which case it SHALL load the new result and keep meas_valid=1.
REQ-023 If a publish occurs while meas_valid=1 and meas_ready=0, the new result SHALL be dropped, the held result kept, and overrun set.
REQ-024 Counters SHALL never wrap, because the timeout bounds them at TIMEOUT.
REQ-025 A result SHALL always satisfy 1 <= width < period <= TIMEOUT.

Reset
REQ-026 While rst_n=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, and the synchronizer, counters and output register SHALL be cleared.
REQ-027 An asserted reset SHALL abort any in-progress measurement and discard the held result, with no timeout pulse.
REQ-028 After rst_n deasserts, the first measurement SHALL begin only on a fresh rise; a DATA_IN already high at release SHALL NOT be counted until it falls and rises again.

Structure
REQ-029 The state encoding (IDLE=2'b00, HIGH=2'b01, LOW=2'b10) SHALL be defined in a shared package pulse_pkg, reused by the pulse-test top level.
REQ-030 The synchronizer and edge logic SHALL be one sub-module, pulse_sync_edge, with outputs s, rise and fall.
REQ-031 The FSM, counters and output register SHALL reside in pulse_meter.

Verification
REQ-032 DATA_IN high for 4 cycles, period 10, meas_ready=1 -> results width=4, period=10, repeated every 10 cycles.
REQ-033 A single rise then DATA_IN held low with TIMEOUT=1000 -> one timeout pulse at pcnt=1000, meas_valid stays 0, busy falls.
REQ-034 meas_ready=0 across two periods of a 3/8 pulse train -> first result (3,8) held stable, overrun=1, second result dropped.
REQ-035 A period exactly equal to TIMEOUT (rise at pcnt=1000) -> result period=1000, no timeout.
REQ-036 rst_n asserted mid-HIGH, then released with DATA_IN high -> outputs 0; the next result is produced only after a fresh low-to-high transition.
